// File: rtl/reaction_ctrl_if.sv
// Reaction-timer player/display bus: start and react buttons in,
// reaction count, lamp and status flags out.
interface reaction_ctrl_if;
  logic start;
  logic react;
  logic Q3;
  logic Q2;
  logic Q1;
  logic Q0;
  logic led;
  logic done;
  logic early;

  // Drives buttons, observes results (player side / testbench)
  modport master (
    output start, react,
    input  Q3, Q2, Q1, Q0, led, done, early
  );

  // Controller side
  modport slave (
    input  start, react,
    output Q3, Q2, Q1, Q0, led, done, early
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller. A start edge arms a pseudo-random delay;
// the lamp then lights and the tick count until the react edge is the score.
// Optional false-start detection is compiled in with macro EARLY_DETECT_EN.
module reaction_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int MIN_DELAY = 4
) (
  input logic           clk,
  input logic           rst,
  reaction_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ARMED,
    S_DONE
`ifdef EARLY_DETECT_EN
    , S_EARLY
`endif
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_start_d;
  logic            r_react_d;
  logic [PW-1:0]   r_presc;
  logic [3:0]      r_lfsr;
  logic [4:0]      r_delay;
  logic [3:0]      r_q;
  logic            r_led;
  logic            r_done;
  logic            w_start_edge;
  logic            w_react_edge;
  logic            w_tick;

  assign w_start_edge = bus.start & ~r_start_d;
  assign w_react_edge = bus.react & ~r_react_d;
  assign w_tick       = (r_presc == PW'(TICK_DIV - 1));

  // Registered copies of the buttons for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_react_d <= 1'b0;
    end else begin
      r_start_d <= bus.start;
      r_react_d <= bus.react;
    end
  end

  // Free-running x^4+x^3+1 LFSR; nonzero seed keeps it out of 0000
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 4'b1001;
    else     r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  end

  // Tick prescaler, restarted whenever the FSM changes state
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state) || w_tick) r_presc <= '0;
    else                                      r_presc <= r_presc + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_next = S_DELAY;
      S_DELAY: begin
`ifdef EARLY_DETECT_EN
        // react checked first so a press on the expiry clock is still early
        if (w_react_edge)          w_next = S_EARLY;
        else if (r_delay == '0)    w_next = S_ARMED;
`else
        if (r_delay == '0)         w_next = S_ARMED;
`endif
      end
      S_ARMED: if (w_react_edge) w_next = S_DONE;
      S_DONE:  if (w_start_edge) w_next = S_DELAY;
`ifdef EARLY_DETECT_EN
      S_EARLY: if (w_start_edge) w_next = S_DELAY;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Delay counter, reaction count and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_delay <= '0;
      r_q     <= '0;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_led  <= (w_next == S_ARMED);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_DELAY: begin
          if (w_tick && (r_delay != '0)) r_delay <= r_delay - 1'b1;
`ifdef EARLY_DETECT_EN
          if (w_next == S_EARLY) r_q <= '1;
`endif
        end
        // react wins over a coincident tick: count freezes this cycle
        S_ARMED: if (!w_react_edge && w_tick && (r_q != '1)) r_q <= r_q + 1'b1;
        default: begin
          if (w_start_edge) begin
            r_delay <= {1'b0, r_lfsr} + 5'(MIN_DELAY);
            r_q     <= '0;
          end
        end
      endcase
    end
  end

`ifdef EARLY_DETECT_EN
  logic r_early;

  // False-start flag
  always_ff @(posedge clk) begin
    if (rst) r_early <= 1'b0;
    else     r_early <= (w_next == S_EARLY);
  end

  assign bus.early = r_early;
`else
  assign bus.early = 1'b0;
`endif

  assign bus.Q3   = r_q[3];
  assign bus.Q2   = r_q[2];
  assign bus.Q1   = r_q[1];
  assign bus.Q0   = r_q[0];
  assign bus.led  = r_led;
  assign bus.done = r_done;
endmodule
